// File: rtl/best_move_sel_pkg.sv
// Shared types and defaults for the best-move selector.
package best_move_sel_pkg;

    // Frame lifecycle: no frame open, frame open, result held.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam int unsigned DefScoreW = 6;
    localparam int unsigned DefMoveW  = 12;
    localparam int unsigned SqW       = 6;

    // Move tag layout: from-square in the upper half, to-square in the lower half.
    typedef struct packed {
        logic [SqW-1:0] from_sq;
        logic [SqW-1:0] to_sq;
    } move_t;

    function automatic logic [SqW-1:0] move_from(input move_t m);
        return m.from_sq;
    endfunction

    function automatic logic [SqW-1:0] move_to(input move_t m);
        return m.to_sq;
    endfunction

endpackage

// File: rtl/best_move_sel_score_cmp.sv
// Combinational better-than test between a candidate and the incumbent best.
module score_cmp
    import best_move_sel_pkg::*;
#(
    parameter int unsigned SCORE_W = DefScoreW
) (
    input  logic [SCORE_W-1:0] cand_score_i,
    input  logic [SCORE_W-1:0] best_score_i,
    input  logic               min_mode_i,
    input  logic               tie_last_i,
    output logic               replace_o
);

    // Strictly better wins; equal scores fall back to the tie rule.
    always_comb begin
        replace_o = 1'b0;
        if (cand_score_i == best_score_i) begin
            replace_o = tie_last_i;
        end else if (min_mode_i) begin
            replace_o = (cand_score_i < best_score_i);
        end else begin
            replace_o = (cand_score_i > best_score_i);
        end
    end

endmodule

// File: rtl/best_move_sel.sv
// Streams scored candidate moves and reports the best one per frame.
module best_move_sel
    import best_move_sel_pkg::*;
#(
    parameter int unsigned SCORE_W  = DefScoreW,
    parameter int unsigned MOVE_W   = DefMoveW,
    parameter int unsigned MAX_CAND = 64,
    parameter int unsigned TIE_LAST = 1,
    localparam int unsigned CNT_W   = $clog2(MAX_CAND + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SCORE_W-1:0] in_score,
    input  logic [MOVE_W-1:0]  in_move,
    input  logic               in_last,
    input  logic               in_min,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SCORE_W-1:0] out_score,
    output logic [MOVE_W-1:0]  out_move,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_ovf
);

    localparam logic [CNT_W-1:0] CountMax = CNT_W'(MAX_CAND);
    localparam logic [CNT_W-1:0] CountOne = CNT_W'(1);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] best_score_q, best_score_d;
    logic [MOVE_W-1:0]  best_move_q, best_move_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               min_q, min_d;

    logic transfer;
    logic replace;

    assign in_ready = (state_q != StDone);
    assign transfer = in_valid && in_ready;

    score_cmp #(
        .SCORE_W (SCORE_W)
    ) u_score_cmp (
        .cand_score_i (in_score),
        .best_score_i (best_score_q),
        .min_mode_i   (min_q),
        .tie_last_i   (TIE_LAST != 0),
        .replace_o    (replace)
    );

    // Next-state: abort beats a transfer; DONE only waits for the consumer.
    always_comb begin
        state_d      = state_q;
        best_score_d = best_score_q;
        best_move_d  = best_move_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        min_d        = min_q;

        unique case (state_q)
            StIdle: begin
                if (abort) begin
                    best_score_d = '0;
                    best_move_d  = '0;
                    count_d      = '0;
                    ovf_d        = 1'b0;
                end else if (transfer) begin
                    best_score_d = in_score;
                    best_move_d  = in_move;
                    min_d        = in_min;
                    count_d      = CountOne;
                    ovf_d        = 1'b0;
                    state_d      = in_last ? StDone : StAccum;
                end
            end
            StAccum: begin
                if (abort) begin
                    best_score_d = '0;
                    best_move_d  = '0;
                    count_d      = '0;
                    ovf_d        = 1'b0;
                    state_d      = StIdle;
                end else if (transfer) begin
                    if (replace) begin
                        best_score_d = in_score;
                        best_move_d  = in_move;
                    end
                    // Saturated count: flag the overflow but keep comparing.
                    if (count_q == CountMax) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CountOne;
                    end
                    if (in_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            best_score_q <= '0;
            best_move_q  <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            min_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            best_score_q <= best_score_d;
            best_move_q  <= best_move_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            min_q        <= min_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign out_score = best_score_q;
    assign out_move  = best_move_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_best_move_sel.sv
// Randomized self-checking bench; two instances differ only in tie rule.
module tb_best_move_sel;

    localparam int SW = 6;
    localparam int MW = 12;
    localparam int MAXC = 64;
    localparam int CW = 7;
    localparam int RW = 1 + SW + MW + CW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [SW-1:0] in_score = '0;
    logic [MW-1:0] in_move = '0;
    logic          in_last = 1'b0;
    logic          in_min = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;

    logic          rdy1, vld1, ovf1;
    logic [SW-1:0] sc1;
    logic [MW-1:0] mv1;
    logic [CW-1:0] cn1;
    logic          rdy0, vld0, ovf0;
    logic [SW-1:0] sc0;
    logic [MW-1:0] mv0;
    logic [CW-1:0] cn0;

    logic [RW-1:0] res1, res0;
    assign res1 = {vld1, sc1, mv1, cn1, ovf1};
    assign res0 = {vld0, sc0, mv0, cn0, ovf0};

    int tests = 0;
    int fails = 0;

    int          sc[$];
    logic [MW-1:0] mv[$];
    bit          fmode;

    always #5 clk = ~clk;

    best_move_sel #(.SCORE_W(SW), .MOVE_W(MW), .MAX_CAND(MAXC), .TIE_LAST(1)) u_tie1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_score(in_score), .in_move(in_move), .in_last(in_last), .in_min(in_min),
        .abort(abort), .out_valid(vld1), .out_ready(out_ready), .out_score(sc1),
        .out_move(mv1), .out_count(cn1), .out_ovf(ovf1)
    );

    best_move_sel #(.SCORE_W(SW), .MOVE_W(MW), .MAX_CAND(MAXC), .TIE_LAST(0)) u_tie0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_score(in_score), .in_move(in_move), .in_last(in_last), .in_min(in_min),
        .abort(abort), .out_valid(vld0), .out_ready(out_ready), .out_score(sc0),
        .out_move(mv0), .out_count(cn0), .out_ovf(ovf0)
    );

    // Reference: find the extreme value, then pick its first or last occurrence.
    function automatic logic [RW-1:0] model(input bit tie_last);
        int ext;
        int idx;
        int n;
        n = sc.size();
        ext = sc[0];
        foreach (sc[i]) begin
            if (fmode ? (sc[i] < ext) : (sc[i] > ext)) ext = sc[i];
        end
        idx = -1;
        foreach (sc[i]) begin
            if (sc[i] == ext && (idx < 0 || tie_last)) idx = i;
        end
        return {1'b1, SW'(ext), mv[idx], CW'((n > MAXC) ? MAXC : n), (n > MAXC) ? 1'b1 : 1'b0};
    endfunction

    // Streams the queued frame; in_min only matters on the first beat, so it is
    // flipped afterwards to prove it is ignored.
    task automatic send_frame(input bit with_last);
        for (int i = 0; i < sc.size(); i++) begin
            in_valid = 1'b1;
            in_score = SW'(sc[i]);
            in_move  = mv[i];
            in_last  = with_last && (i == sc.size() - 1);
            in_min   = (i == 0) ? fmode : ~fmode;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic load(input int n, input int maxv);
        sc.delete();
        mv.delete();
        for (int i = 0; i < n; i++) begin
            sc.push_back(int'($urandom_range(0, maxv)));
            mv.push_back(MW'($urandom));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        abort = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        tests++;
        if ({rdy1, res1} !== {1'b1, {RW{1'b0}}}) begin
            fails++;
            $display("FAIL reset tie1: got %h want %h", {rdy1, res1}, {1'b1, {RW{1'b0}}});
        end
        tests++;
        if ({rdy0, res0} !== {1'b1, {RW{1'b0}}}) begin
            fails++;
            $display("FAIL reset tie0: got %h want %h", {rdy0, res0}, {1'b1, {RW{1'b0}}});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_max_tie();
        logic [RW-1:0] e1, e0;
        load(5, 0);
        sc = '{3, 17, 9, 17, 2};
        fmode = 1'b0;
        e1 = model(1);
        e0 = model(0);
        send_frame(1'b1);
        tests++;
        if (res1 !== e1 || e1[CW+1+MW-1 -: MW] !== mv[3]) begin
            fails++;
            $display("FAIL max_tie tie1: got %h want %h", res1, e1);
        end
        tests++;
        if (res0 !== e0) begin
            fails++;
            $display("FAIL max_tie tie0: got %h want %h", res0, e0);
        end
        consume();
        tests++;
        if ({vld1, vld0, rdy1, rdy0} !== 4'b0011) begin
            fails++;
            $display("FAIL max_tie consume: got %b want 0011", {vld1, vld0, rdy1, rdy0});
        end
    endtask

    task automatic test_min();
        logic [RW-1:0] e1, e0;
        load(5, 0);
        sc = '{3, 17, 9, 17, 2};
        fmode = 1'b1;
        e0 = model(0);
        send_frame(1'b1);
        tests++;
        if (res0 !== e0 || sc0 !== 6'd2 || mv0 !== mv[4]) begin
            fails++;
            $display("FAIL min_5 tie0: got %h want %h", res0, e0);
        end
        consume();
        load(3, 0);
        sc = '{3, 2, 2};
        e1 = model(1);
        e0 = model(0);
        send_frame(1'b1);
        tests++;
        if (res0 !== e0 || mv0 !== mv[1]) begin
            fails++;
            $display("FAIL min_322 tie0: got %h want %h", res0, e0);
        end
        tests++;
        if (res1 !== e1 || mv1 !== mv[2]) begin
            fails++;
            $display("FAIL min_322 tie1: got %h want %h", res1, e1);
        end
        consume();
    endtask

    task automatic test_random();
        logic [RW-1:0] e1, e0;
        for (int f = 0; f < 30; f++) begin
            load(int'($urandom_range(1, 9)), (f < 15) ? 7 : 63);
            fmode = 1'($urandom);
            e1 = model(1);
            e0 = model(0);
            send_frame(1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            tests++;
            if (res1 !== e1) begin
                fails++;
                $display("FAIL random %0d tie1: got %h want %h", f, res1, e1);
            end
            tests++;
            if (res0 !== e0) begin
                fails++;
                $display("FAIL random %0d tie0: got %h want %h", f, res0, e0);
            end
            consume();
        end
    endtask

    task automatic test_ovf();
        logic [RW-1:0] e1;
        sc.delete();
        mv.delete();
        for (int i = 0; i < 65; i++) begin
            sc.push_back((i < 64) ? i : 0);
            mv.push_back(MW'($urandom));
        end
        fmode = 1'b0;
        e1 = model(1);
        send_frame(1'b1);
        tests++;
        if (res1 !== e1 || sc1 !== 6'd63 || cn1 !== 7'd64 || ovf1 !== 1'b1) begin
            fails++;
            $display("FAIL ovf tie1: got %h want %h", res1, e1);
        end
        tests++;
        if (res0 !== e1) begin
            fails++;
            $display("FAIL ovf tie0: got %h want %h", res0, e1);
        end
        consume();
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] e1;
        load(4, 63);
        fmode = 1'b0;
        e1 = model(1);
        send_frame(1'b1);
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_score = 6'd63;
        in_move  = 12'hfff;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            tests++;
            if ({rdy1, res1} !== {1'b0, e1}) begin
                fails++;
                $display("FAIL hold cycle %0d: got %h want %h", c, {rdy1, res1}, {1'b0, e1});
            end
        end
        consume();
        in_valid = 1'b0;
        in_last  = 1'b0;
        tests++;
        if ({vld1, rdy1} !== 2'b01) begin
            fails++;
            $display("FAIL hold release: got %b want 01", {vld1, rdy1});
        end
        @(posedge clk); #1;
        tests++;
        if ({vld1, vld0} !== 2'b00) begin
            fails++;
            $display("FAIL hold no_accept: got %b want 00", {vld1, vld0});
        end
    endtask

    task automatic test_abort();
        logic [RW-1:0] e1;
        load(3, 63);
        fmode = 1'b0;
        send_frame(1'b0);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_score = 6'd40;
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({vld1, cn1, sc1, ovf1} !== '0) begin
            fails++;
            $display("FAIL abort clear: got %h want 0", {vld1, cn1, sc1, ovf1});
        end
        load(1, 0);
        sc[0] = 5;
        e1 = model(1);
        send_frame(1'b1);
        tests++;
        if (res1 !== e1 || cn1 !== 7'd1) begin
            fails++;
            $display("FAIL abort then single: got %h want %h", res1, e1);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        tests++;
        if (res0 !== e1) begin
            fails++;
            $display("FAIL abort in done: got %h want %h", res0, e1);
        end
        consume();
    endtask

    task automatic test_reset_midframe();
        logic [RW-1:0] e1;
        load(2, 63);
        fmode = 1'b1;
        send_frame(1'b0);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_last  = 1'b1;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        tests++;
        if ({rdy1, res1} !== {1'b1, {RW{1'b0}}}) begin
            fails++;
            $display("FAIL reset midframe: got %h want %h", {rdy1, res1}, {1'b1, {RW{1'b0}}});
        end
        load(3, 7);
        fmode = 1'b0;
        e1 = model(1);
        send_frame(1'b1);
        tests++;
        if (res1 !== e1) begin
            fails++;
            $display("FAIL after reset frame: got %h want %h", res1, e1);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_max_tie();
        test_min();
        test_random();
        test_ovf();
        test_backpressure();
        test_abort();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
